enc_binder_bank: RTL and testbench

Parametrised, streaming successor to the fixed 16-lane binder pack in the sparse HDC encoder. Binds `LANES` level hypervectors per beat by cyclic rotation. Each rotation amount comes from the shared `SHIFTS` table. A frame of `GROUPS` beats covers `LANES*GROUPS` features, so one bank instance can time-multiplex any feature count. The block adds valid/ready flow control, a 2-stage pipeline, per-frame bind/unbind direction, and frame sequencing, which the fixed pack lacks.

---
 rtl/hdc_pkg.sv | 29 ++
 rtl/hv_rotator.sv | 29 ++
 rtl/enc_binder_bank.sv | 159 +++++++++++++++
 tb/tb_enc_binder_bank.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hdc_pkg.sv
// Shared definitions for the sparse HDC encoder.
// Holds the default hypervector width, the number of features bound per
// clock by default, the shared rotation table (SHIFTS) and the binder FSM
// state type. SHIFTS entries are raw amounts; users reduce them modulo the
// hypervector width, so entries may exceed HV_DIM.
package hdc_pkg;

  localparam int unsigned HV_DIM          = 32'd1024;
  localparam int unsigned FEATURES_PER_CC = 32'd16;
  localparam int unsigned SHIFTS_N        = 32'd64;

  localparam logic [15:0] SHIFTS [0:SHIFTS_N-1] = '{
    16'd1,   16'd3,   16'd0,   16'd9,   16'd7,   16'd12,  16'd5,   16'd2,
    16'd17,  16'd40,  16'd63,  16'd101, 16'd255, 16'd256, 16'd300, 16'd511,
    16'd512, 16'd600, 16'd777, 16'd900, 16'd1023,16'd1024,16'd1500,16'd33,
    16'd44,  16'd55,  16'd66,  16'd77,  16'd88,  16'd99,  16'd111, 16'd222,
    16'd333, 16'd444, 16'd555, 16'd666, 16'd888, 16'd999, 16'd123, 16'd234,
    16'd345, 16'd456, 16'd567, 16'd678, 16'd789, 16'd890, 16'd901, 16'd12,
    16'd23,  16'd34,  16'd45,  16'd56,  16'd67,  16'd78,  16'd89,  16'd91,
    16'd4,   16'd8,   16'd16,  16'd32,  16'd64,  16'd128, 16'd2048,16'd4095
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } enc_state_e;

endpackage

// File: rtl/hv_rotator.sv
// Purely combinational cyclic rotator for one hypervector.
// Ports:
//   hv     - input hypervector
//   amt    - rotation amount, already reduced below HV_DIM
//   dir    - 0: rotate left  (out[(k+amt) mod HV_DIM] = hv[k])
//            1: rotate right (out[k] = hv[(k+amt) mod HV_DIM])
//   rot_hv - rotated hypervector
module hv_rotator #(
  parameter  int unsigned HV_DIM = 32'd1024,
  localparam int unsigned AW     = (HV_DIM > 32'd1) ? $clog2(HV_DIM) : 32'd1
) (
  input  logic [HV_DIM-1:0] hv,
  input  logic [AW-1:0]     amt,
  input  logic              dir,
  output logic [HV_DIM-1:0] rot_hv
);

  // Rotation as two opposing shifts OR-ed together; a shift by HV_DIM
  // yields zero, so amt == 0 passes hv through unchanged.
  always_comb begin
    rot_hv = {HV_DIM{1'b0}};
    if (dir) begin
      rot_hv = (hv >> amt) | (hv << (HV_DIM - 32'(amt)));
    end else begin
      rot_hv = (hv << amt) | (hv >> (HV_DIM - 32'(amt)));
    end
  end

endmodule

// File: rtl/enc_binder_bank.sv
// Streaming binder bank: binds LANES level hypervectors per beat by cyclic
// rotation, GROUPS beats per frame, with valid/ready flow control through a
// 2-stage pipeline (S1: operands + amounts, S2: rotated result).
// Ports:
//   clk, nrst              - clock, synchronous active-high reset
//   start_encoding, unbind - frame start (IDLE only) and frame direction
//   in_valid/in_ready      - input beat handshake, level_hv per lane
//   out_valid/out_ready    - output beat handshake, shifted_hv per lane
//   out_group, out_last    - group index / last-of-frame flag of output beat
//   frame_done             - pulse when the last beat is taken downstream
//   busy                   - a frame is in progress
module enc_binder_bank #(
  parameter  int unsigned HV_DIM     = hdc_pkg::HV_DIM,
  parameter  int unsigned LANES      = hdc_pkg::FEATURES_PER_CC,
  parameter  int unsigned GROUPS     = 32'd4,
  parameter  int unsigned SHIFT_BASE = 32'd0,
  localparam int unsigned GW         = (GROUPS > 32'd1) ? $clog2(GROUPS) : 32'd1,
  localparam int unsigned AW         = (HV_DIM > 32'd1) ? $clog2(HV_DIM) : 32'd1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_encoding,
  input  logic              unbind,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HV_DIM-1:0] level_hv [0:LANES-1],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HV_DIM-1:0] shifted_hv [0:LANES-1],
  output logic [GW-1:0]     out_group,
  output logic              out_last,
  output logic              frame_done,
  output logic              busy
);

  import hdc_pkg::*;

  localparam int unsigned SIW = $clog2(SHIFTS_N);

  if (SHIFT_BASE + LANES * GROUPS > SHIFTS_N) begin : g_shift_range_err
    $error("enc_binder_bank: SHIFT_BASE + LANES*GROUPS exceeds the SHIFTS table");
  end

  enc_state_e        state_r, state_s;
  logic              dir_q;
  logic [GW-1:0]     grp_q;
  logic              s2_ready_s, s1_ready_s, accept_s, last_in_s;
  logic [AW-1:0]     amt_s    [0:LANES-1];
  logic              s1_valid_r, s1_last_r, s1_dir_r;
  logic [GW-1:0]     s1_grp_r;
  logic [HV_DIM-1:0] s1_hv_r  [0:LANES-1];
  logic [AW-1:0]     s1_amt_r [0:LANES-1];
  logic [HV_DIM-1:0] rot_s    [0:LANES-1];

  assign s2_ready_s = !out_valid || out_ready;
  assign s1_ready_s = !s1_valid_r || s2_ready_s;
  assign in_ready   = (state_r == RUN) && s1_ready_s;
  assign accept_s   = in_valid && in_ready;
  assign last_in_s  = (grp_q == GW'(GROUPS - 32'd1));
  assign frame_done = out_valid && out_ready && out_last;
  assign busy       = (state_r != IDLE);

  // Per-lane rotation amount for the group currently being accepted
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      amt_s[i] = AW'(32'(SHIFTS[SIW'(SHIFT_BASE + 32'(grp_q) * LANES + i)]) % HV_DIM);
    end
  end

  // Next-state logic; a start coinciding with frame_done is lost because
  // the FSM is still in DRAIN on that cycle
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_encoding) state_s = RUN;
        else                state_s = IDLE;
      end
      RUN: begin
        if (accept_s && last_in_s) state_s = DRAIN;
        else                       state_s = RUN;
      end
      DRAIN: begin
        if (frame_done) state_s = IDLE;
        else            state_s = DRAIN;
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state, frame direction and group counter
  always_ff @(posedge clk) begin
    if (nrst) begin
      state_r <= IDLE;
      dir_q   <= 1'b0;
      grp_q   <= {GW{1'b0}};
    end else begin
      state_r <= state_s;
      if (state_r == IDLE && start_encoding) begin
        dir_q <= unbind;
        grp_q <= {GW{1'b0}};
      end else if (accept_s) begin
        grp_q <= grp_q + GW'(1'b1);
      end
    end
  end

  // Stage 1: capture the accepted beat together with its amounts and tags
  always_ff @(posedge clk) begin
    if (nrst) begin
      s1_valid_r <= 1'b0;
      s1_grp_r   <= {GW{1'b0}};
      s1_last_r  <= 1'b0;
      s1_dir_r   <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
        s1_hv_r[i]  <= {HV_DIM{1'b0}};
        s1_amt_r[i] <= {AW{1'b0}};
      end
    end else if (s1_ready_s) begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_hv_r   <= level_hv;
        s1_amt_r  <= amt_s;
        s1_grp_r  <= grp_q;
        s1_last_r <= last_in_s;
        s1_dir_r  <= dir_q;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    hv_rotator #(.HV_DIM(HV_DIM)) u_rot (
      .hv     (s1_hv_r[i]),
      .amt    (s1_amt_r[i]),
      .dir    (s1_dir_r),
      .rot_hv (rot_s[i])
    );
  end

  // Stage 2: registered rotated result drives the outputs directly
  always_ff @(posedge clk) begin
    if (nrst) begin
      out_valid <= 1'b0;
      out_group <= {GW{1'b0}};
      out_last  <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
        shifted_hv[i] <= {HV_DIM{1'b0}};
      end
    end else if (s2_ready_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        shifted_hv <= rot_s;
        out_group  <= s1_grp_r;
        out_last   <= s1_last_r;
      end
    end
  end

endmodule

// File: tb/tb_enc_binder_bank.sv
// Self-checking bench for enc_binder_bank with HV_DIM=8, LANES=2, GROUPS=4.
// A queue-based reference model predicts handshakes, latency and the bound
// values; directed frames also check fixed expected constants.
module tb_enc_binder_bank;

  localparam int unsigned W = 8;
  localparam int unsigned L = 2;
  localparam int unsigned G = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

  logic       clk = 1'b0;
  logic       nrst, start_encoding, unbind, in_valid, in_ready;
  logic [7:0] level_hv   [0:1];
  logic       out_valid, out_ready;
  logic [7:0] shifted_hv [0:1];
  logic [1:0] out_group;
  logic       out_last, frame_done, busy;

  enc_binder_bank #(.HV_DIM(W), .LANES(L), .GROUPS(G), .SHIFT_BASE(0)) dut (
    .clk(clk), .nrst(nrst), .start_encoding(start_encoding), .unbind(unbind),
    .in_valid(in_valid), .in_ready(in_ready), .level_hv(level_hv),
    .out_valid(out_valid), .out_ready(out_ready), .shifted_hv(shifted_hv),
    .out_group(out_group), .out_last(out_last), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  grp;
    logic        last;
    logic [7:0]  age;
  } beat_t;

  beat_t       q[$];
  logic [15:0] cap_d[$];
  logic [1:0]  cap_g[$];
  logic [15:0] fd [0:3];
  int          mstate, mgrp, ncmp, nerr, obs_fd, fd_mark;
  bit          mdir;

  // Shared rotation table entries used by this instance (indices 0..7).
  function automatic int unsigned shift_of(int g, int lane);
    case (g * 2 + lane)
      0: return 1;  1: return 3;  2: return 0;  3: return 9;
      4: return 7;  5: return 12; 6: return 5;  default: return 2;
    endcase
  endfunction

  function automatic logic [7:0] rot(logic [7:0] v, int unsigned s, bit right);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (!right) r[(k + s) % 8] = v[k];
      else        r[k] = v[(k + s) % 8];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, advance the model, step.
  task automatic tick();
    bit          vis, exp_ir, exp_fd;
    beat_t       b;
    logic [15:0] lv;
    int          prev;
    #1;
    vis    = (q.size() > 0) && (q[0].age >= 8'd1);
    exp_ir = (mstate == M_RUN) && ((q.size() < 2) || out_ready);
    exp_fd = vis && out_ready && q[0].last;
    chk("busy",       16'(busy),       16'(mstate != M_IDLE));
    chk("in_ready",   16'(in_ready),   16'(exp_ir));
    chk("out_valid",  16'(out_valid),  16'(vis));
    chk("frame_done", 16'(frame_done), 16'(exp_fd));
    if (vis) begin
      chk("lane0",     16'(shifted_hv[0]), 16'(q[0].data[7:0]));
      chk("lane1",     16'(shifted_hv[1]), 16'(q[0].data[15:8]));
      chk("out_group", 16'(out_group),     16'(q[0].grp));
      chk("out_last",  16'(out_last),      16'(q[0].last));
    end
    if (frame_done === 1'b1) obs_fd++;
    if (nrst) begin
      q.delete();
      mstate = M_IDLE; mgrp = 0; mdir = 1'b0;
    end else begin
      prev = mstate;
      if (vis && out_ready) begin
        cap_d.push_back({shifted_hv[1], shifted_hv[0]});
        cap_g.push_back(out_group);
        if (q[0].last) mstate = M_IDLE;
        void'(q.pop_front());
      end
      foreach (q[i]) q[i].age = q[i].age + 8'd1;
      if (in_valid && exp_ir) begin
        lv = {level_hv[1], level_hv[0]};
        b.data = {rot(lv[15:8], shift_of(mgrp, 1) % 8, mdir),
                  rot(lv[7:0],  shift_of(mgrp, 0) % 8, mdir)};
        b.grp  = 2'(mgrp);
        b.last = (mgrp == G - 1);
        b.age  = 8'd0;
        q.push_back(b);
        mgrp++;
        if (mgrp == G) mstate = M_DRAIN;
      end
      if (prev == M_IDLE && start_encoding) begin
        mstate = M_RUN; mdir = unbind; mgrp = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  // Start a frame and drive it until the model returns to IDLE.
  task automatic run_frame(input bit ub, input int pv, input int pr,
                           input int stall_at, input bit abuse);
    int cyc;
    in_valid = 1'b0; out_ready = 1'b1; start_encoding = 1'b1; unbind = ub;
    tick();
    start_encoding = 1'b0;
    cyc = 0;
    while (mstate != M_IDLE && cyc < 300) begin
      in_valid    = ($urandom_range(99) < pv);
      level_hv[0] = fd[mgrp[1:0]][7:0];
      level_hv[1] = fd[mgrp[1:0]][15:8];
      out_ready   = ($urandom_range(99) < pr) && !(cyc >= stall_at && cyc < stall_at + 5);
      start_encoding = abuse && ($urandom_range(2) == 0);
      unbind      = !ub;
      tick();
      cyc++;
    end
    start_encoding = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("frame_timeout", 16'(cyc >= 300), 16'd0);
  endtask

  task automatic rand_fd();
    for (int i = 0; i < 4; i++) fd[i] = 16'($urandom);
  endtask

  initial begin
    ncmp = 0; nerr = 0; obs_fd = 0;
    mstate = M_IDLE; mgrp = 0; mdir = 1'b0;
    nrst = 1'b1; start_encoding = 1'b0; unbind = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; level_hv[0] = 8'h00; level_hv[1] = 8'h00;
    @(posedge clk); #1;
    tick();
    nrst = 1'b0;
    // Reset values
    chk("rst_out_group", 16'(out_group), 16'd0);
    chk("rst_out_last",  16'(out_last),  16'd0);
    chk("rst_lane0",     16'(shifted_hv[0]), 16'd0);
    chk("rst_lane1",     16'(shifted_hv[1]), 16'd0);

    // in_valid while IDLE is ignored
    in_valid = 1'b1; level_hv[0] = 8'h5A; level_hv[1] = 8'hA5;
    repeat (3) tick();
    in_valid = 1'b0;

    // Basic bind
    for (int i = 0; i < 4; i++) fd[i] = 16'h8101;
    cap_d.delete(); cap_g.delete(); fd_mark = obs_fd;
    run_frame(1'b0, 100, 100, 99, 1'b0);
    chk("bind_beats", 16'(cap_d.size()), 16'd4);
    chk("bind_g0",    cap_d[0], 16'h0C02);
    chk("bind_g1",    cap_d[1], 16'h0301);
    chk("bind_fd",    16'(obs_fd - fd_mark), 16'd1);

    // Unbind replays the group 0 result
    rand_fd(); fd[0] = 16'h0C02;
    cap_d.delete(); cap_g.delete();
    run_frame(1'b1, 100, 100, 99, 1'b0);
    chk("unbind_g0", cap_d[0], 16'h8101);

    // Backpressure mid-frame plus start_encoding abuse during RUN/DRAIN
    rand_fd(); cap_d.delete(); cap_g.delete();
    run_frame(1'b0, 100, 100, 1, 1'b1);
    chk("bp_beats", 16'(cap_g.size()), 16'd4);
    for (int i = 0; i < 4; i++) chk("bp_order", 16'(cap_g[i]), 16'(i));

    // Reset after the first accept
    rand_fd(); fd_mark = obs_fd;
    start_encoding = 1'b1; unbind = 1'b0; tick();
    start_encoding = 1'b0;
    in_valid = 1'b1; level_hv[0] = fd[0][7:0]; level_hv[1] = fd[0][15:8]; tick();
    in_valid = 1'b0; nrst = 1'b1; tick();
    nrst = 1'b0;
    repeat (4) tick();
    chk("rst_mid_fd", 16'(obs_fd - fd_mark), 16'd0);
    rand_fd(); run_frame(1'b1, 100, 100, 99, 1'b0);

    // Back-to-back frames
    fd_mark = obs_fd;
    rand_fd(); run_frame(1'b0, 100, 100, 99, 1'b0);
    cap_g.delete();
    rand_fd(); run_frame(1'b1, 100, 100, 99, 1'b0);
    chk("b2b_first_grp", 16'(cap_g[0]), 16'd0);
    chk("b2b_fd",        16'(obs_fd - fd_mark), 16'd2);

    // Random frames
    for (int f = 0; f < 25; f++) begin
      rand_fd();
      run_frame(1'($urandom_range(1)), int'($urandom_range(100, 50)),
                int'($urandom_range(100, 30)), int'($urandom_range(8)), 1'b1);
      repeat ($urandom_range(2)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
